// File: rtl/user_pwm_reg_pkg.sv
// Register map, CTRL field positions and OBI bus payload types for user_pwm.
package user_pwm_reg_pkg;

    localparam int unsigned ObiAddrWidth = 32;
    localparam int unsigned ObiDataWidth = 32;
    localparam int unsigned ObiIdWidth   = 4;
    localparam int unsigned ObiBeWidth   = ObiDataWidth / 8;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultCfg = '{
        AddrWidth: ObiAddrWidth,
        DataWidth: ObiDataWidth,
        IdWidth:   ObiIdWidth
    };

    typedef struct packed {
        logic [ObiAddrWidth-1:0] addr;
        logic                    we;
        logic [ObiBeWidth-1:0]   be;
        logic [ObiDataWidth-1:0] wdata;
        logic [ObiIdWidth-1:0]   aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    typedef struct packed {
        logic [ObiDataWidth-1:0] rdata;
        logic [ObiIdWidth-1:0]   rid;
        logic                    err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    // Word indices, i.e. addr[5:2] of each register.
    localparam int unsigned RegCtrlIdx   = 0;
    localparam int unsigned RegPeriodIdx = 1;
    localparam int unsigned RegStatusIdx = 2;
    localparam int unsigned RegCountIdx  = 3;
    localparam int unsigned RegDutyIdx   = 4;

    localparam int unsigned CtrlEnBit    = 0;
    localparam int unsigned CtrlIrqEnBit = 1;
    localparam int unsigned CtrlPrescLsb = 8;
    localparam int unsigned PrescWidth   = 8;
    localparam int unsigned StatusWrapBit = 0;

    // Expand per-byte enables into a per-bit write mask.
    function automatic logic [ObiDataWidth-1:0] be_mask(input logic [ObiBeWidth-1:0] be);
        logic [ObiDataWidth-1:0] m;
        for (int b = 0; b < int'(ObiBeWidth); b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/user_pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter, wrap pulse and active-register load strobe.
module user_pwm_timebase
    import user_pwm_reg_pkg::*;
#(
    parameter int unsigned CntWidth = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [PrescWidth-1:0] presc_i,
    input  logic [CntWidth-1:0]   period_i,
    output logic [CntWidth-1:0]   count_o,
    output logic                  wrap_c_o,
    output logic                  load_c_o
);

    logic [PrescWidth-1:0] presc_q, presc_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  tick_c;

    // >= keeps the prescaler bounded if PRESC is lowered below the running count.
    assign tick_c   = en_i && (presc_q >= presc_i);
    assign wrap_c_o = tick_c && (cnt_q == period_i);
    assign load_c_o = wrap_c_o || !en_i;
    assign count_o  = cnt_q;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (!en_i) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick_c) begin
            presc_d = '0;
            cnt_d   = wrap_c_o ? '0 : cnt_q + CntWidth'(1);
        end else begin
            presc_d = presc_q + PrescWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/user_pwm.sv
// OBI subordinate with NumChannels edge-aligned PWM outputs on a shared timebase,
// double-buffered period/duty registers and a period-wrap interrupt.
module user_pwm #(
    parameter user_pwm_reg_pkg::obi_cfg_t ObiCfg = user_pwm_reg_pkg::ObiDefaultCfg,
    parameter type obi_req_t               = user_pwm_reg_pkg::obi_req_t,
    parameter type obi_rsp_t               = user_pwm_reg_pkg::obi_rsp_t,
    parameter int unsigned NumChannels     = 4,
    parameter int unsigned CntWidth        = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  obi_req_t               obi_req_i,
    output obi_rsp_t               obi_rsp_o,
    output logic [NumChannels-1:0] pwm_o,
    output logic                   irq_o
);
    import user_pwm_reg_pkg::*;

    typedef logic [NumChannels-1:0][CntWidth-1:0] duty_arr_t;

    logic                      en_q, en_d;
    logic                      irq_en_q, irq_en_d;
    logic [PrescWidth-1:0]     presc_q, presc_d;
    logic [CntWidth-1:0]       period_q, period_d;
    logic                      wrap_q, wrap_d;
    duty_arr_t                 duty_q, duty_d;
    logic [CntWidth-1:0]       period_act_q, period_act_d;
    duty_arr_t                 duty_act_q, duty_act_d;
    logic [NumChannels-1:0]    pwm_q, pwm_d;

    logic                      rvalid_q, rvalid_d;
    logic [ObiDataWidth-1:0]   rdata_q, rdata_d;
    logic [ObiCfg.IdWidth-1:0] rid_q, rid_d;
    logic                      err_q, err_d;

    logic [3:0]                idx_c;
    logic                      wr_c;
    logic [ObiDataWidth-1:0]   mask_c;
    logic [ObiDataWidth-1:0]   rd_data_c;
    logic                      dec_err_c;
    logic                      w1c_c;
    logic [CntWidth-1:0]       count;
    logic                      wrap_c;
    logic                      load_c;
    logic                      unused_addr;

    assign idx_c       = obi_req_i.a.addr[5:2];
    assign wr_c        = obi_req_i.req && obi_req_i.a.we;
    assign mask_c      = be_mask(obi_req_i.a.be);
    assign unused_addr = ^{obi_req_i.a.addr[ObiAddrWidth-1:6], obi_req_i.a.addr[1:0]};

    user_pwm_timebase #(
        .CntWidth (CntWidth)
    ) i_timebase (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (en_q),
        .presc_i  (presc_q),
        .period_i (period_act_q),
        .count_o  (count),
        .wrap_c_o (wrap_c),
        .load_c_o (load_c)
    );

    // Read mux and address decode.
    always_comb begin
        rd_data_c = '0;
        dec_err_c = 1'b1;
        case (idx_c)
            4'(RegCtrlIdx): begin
                rd_data_c = ObiDataWidth'({presc_q, 6'b0, irq_en_q, en_q});
                dec_err_c = 1'b0;
            end
            4'(RegPeriodIdx): begin
                rd_data_c = ObiDataWidth'(period_q);
                dec_err_c = 1'b0;
            end
            4'(RegStatusIdx): begin
                rd_data_c = ObiDataWidth'(wrap_q);
                dec_err_c = 1'b0;
            end
            4'(RegCountIdx): begin
                rd_data_c = ObiDataWidth'(count);
                dec_err_c = 1'b0;
            end
            default: ;
        endcase
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (idx_c == 4'(RegDutyIdx + i)) begin
                rd_data_c = ObiDataWidth'(duty_q[i]);
                dec_err_c = 1'b0;
            end
        end
    end

    assign w1c_c = wr_c && (idx_c == 4'(RegStatusIdx)) && obi_req_i.a.be[0]
                   && obi_req_i.a.wdata[StatusWrapBit];

    // Register file next state, double buffering and compare.
    always_comb begin
        en_d         = en_q;
        irq_en_d     = irq_en_q;
        presc_d      = presc_q;
        period_d     = period_q;
        duty_d       = duty_q;
        period_act_d = period_act_q;
        duty_act_d   = duty_act_q;

        if (wr_c) begin
            if (idx_c == 4'(RegCtrlIdx)) begin
                if (obi_req_i.a.be[0]) begin
                    en_d     = obi_req_i.a.wdata[CtrlEnBit];
                    irq_en_d = obi_req_i.a.wdata[CtrlIrqEnBit];
                end
                if (obi_req_i.a.be[1]) begin
                    presc_d = obi_req_i.a.wdata[CtrlPrescLsb +: PrescWidth];
                end
            end
            if (idx_c == 4'(RegPeriodIdx)) begin
                period_d = CntWidth'((ObiDataWidth'(period_q) & ~mask_c)
                                     | (obi_req_i.a.wdata & mask_c));
            end
            for (int unsigned i = 0; i < NumChannels; i++) begin
                if (idx_c == 4'(RegDutyIdx + i)) begin
                    duty_d[i] = CntWidth'((ObiDataWidth'(duty_q[i]) & ~mask_c)
                                          | (obi_req_i.a.wdata & mask_c));
                end
            end
        end

        // A hardware wrap outranks a same-cycle clear.
        wrap_d = wrap_c || (wrap_q && !w1c_c);

        if (load_c) begin
            period_act_d = period_q;
            duty_act_d   = duty_q;
        end

        for (int unsigned i = 0; i < NumChannels; i++) begin
            pwm_d[i] = en_q && (count < duty_act_q[i]);
        end
    end

    // Response captured at the request edge, presented one cycle later.
    always_comb begin
        rvalid_d = obi_req_i.req;
        rdata_d  = rdata_q;
        rid_d    = rid_q;
        err_d    = err_q;
        if (obi_req_i.req) begin
            rdata_d = rd_data_c;
            rid_d   = obi_req_i.a.aid;
            err_d   = dec_err_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q         <= 1'b0;
            irq_en_q     <= 1'b0;
            presc_q      <= '0;
            period_q     <= '0;
            wrap_q       <= 1'b0;
            duty_q       <= '0;
            period_act_q <= '0;
            duty_act_q   <= '0;
            pwm_q        <= '0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            rid_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            en_q         <= en_d;
            irq_en_q     <= irq_en_d;
            presc_q      <= presc_d;
            period_q     <= period_d;
            wrap_q       <= wrap_d;
            duty_q       <= duty_d;
            period_act_q <= period_act_d;
            duty_act_q   <= duty_act_d;
            pwm_q        <= pwm_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            rid_q        <= rid_d;
            err_q        <= err_d;
        end
    end

    always_comb begin
        obi_rsp_o          = '0;
        obi_rsp_o.gnt      = obi_req_i.req;
        obi_rsp_o.rvalid   = rvalid_q;
        obi_rsp_o.r.rdata  = rdata_q;
        obi_rsp_o.r.rid    = rid_q;
        obi_rsp_o.r.err    = err_q;
    end

    assign pwm_o = pwm_q;
    assign irq_o = irq_en_q && wrap_q;

endmodule

// File: tb/tb_user_pwm.sv
// Directed self-checking bench for user_pwm: waveforms, buffering, interrupt, bus and reset.
module tb_user_pwm;
    import user_pwm_reg_pkg::*;

    localparam int unsigned NumCh = 4;
    localparam int unsigned CntW  = 16;

    logic             clk = 1'b0;
    logic             rst;
    obi_req_t         req;
    obi_rsp_t         rsp;
    logic [NumCh-1:0] pwm;
    logic             irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    user_pwm #(
        .ObiCfg      (ObiDefaultCfg),
        .obi_req_t   (obi_req_t),
        .obi_rsp_t   (obi_rsp_t),
        .NumChannels (NumCh),
        .CntWidth    (CntW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .obi_req_i (req),
        .obi_rsp_o (rsp),
        .pwm_o     (pwm),
        .irq_o     (irq)
    );

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] be, output logic err);
        @(negedge clk);
        req         = '0;
        req.req     = 1'b1;
        req.a.addr  = addr;
        req.a.we    = 1'b1;
        req.a.be    = be;
        req.a.wdata = data;
        @(negedge clk);
        req = '0;
        err = rsp.r.err;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [3:0] aid,
                            output logic [31:0] data, output logic err,
                            output logic rv, output logic [3:0] rid);
        @(negedge clk);
        req        = '0;
        req.req    = 1'b1;
        req.a.addr = addr;
        req.a.be   = 4'hF;
        req.a.aid  = aid;
        @(negedge clk);
        req  = '0;
        data = rsp.r.rdata;
        err  = rsp.r.err;
        rv   = rsp.rvalid;
        rid  = rsp.r.rid;
    endtask

    task automatic test_reset();
        logic [31:0] d; logic e, v; logic [3:0] id;
        do_reset();
        n_tests++;
        if ({pwm, irq} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected %b", {pwm, irq}, 5'b0);
        end
        n_tests++;
        if ({rsp.rvalid, rsp.r.err, rsp.r.rdata, rsp.r.rid, rsp.gnt} !== 39'b0) begin
            n_fail++; $display("FAIL reset_rsp: got %h expected 0",
                               {rsp.rvalid, rsp.r.err, rsp.r.rdata, rsp.r.rid, rsp.gnt});
        end
        bus_read(32'h0, 4'h1, d, e, v, id);
        n_tests++;
        if ({v, e, d} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL reset_ctrl_read: got %h expected %h", {v, e, d}, {1'b1, 1'b0, 32'h0});
        end
        bus_read(32'hC, 4'h2, d, e, v, id);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_count: got %h expected 0", d);
        end
    endtask

    task automatic test_basic_pwm();
        logic [19:0] seq; logic [31:0] d; logic e, v; logic [3:0] id;
        do_reset();
        bus_write(32'h4, 32'd9, 4'hF, e);
        bus_write(32'h10, 32'd3, 4'hF, e);
        bus_write(32'h0, 32'h1, 4'hF, e);
        seq = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seq = {seq[18:0], pwm[0]};
        end
        n_tests++;
        if (seq !== 20'b1110000000_1110000000) begin
            n_fail++; $display("FAIL basic_wave: got %b expected %b", seq, 20'b1110000000_1110000000);
        end
        n_tests++;
        if ({pwm[3:1], irq} !== 4'b0) begin
            n_fail++; $display("FAIL basic_idle_ch_irq: got %b expected 0000", {pwm[3:1], irq});
        end
        bus_read(32'h8, 4'h3, d, e, v, id);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL basic_wrap: got %h expected 1", d);
        end
    endtask

    task automatic test_presc_extremes();
        logic [15:0] s0, s1, s2; logic [31:0] d; logic e, v; logic [3:0] id;
        do_reset();
        bus_write(32'h4, 32'd3, 4'hF, e);
        bus_write(32'h10, 32'd2, 4'hF, e);
        bus_write(32'h14, 32'd0, 4'hF, e);
        bus_write(32'h18, 32'd4, 4'hF, e);
        bus_write(32'h0, 32'h0000_0101, 4'hF, e);
        s0 = '0; s1 = '0; s2 = '0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s0 = {s0[14:0], pwm[0]};
            s1 = {s1[14:0], pwm[1]};
            s2 = {s2[14:0], pwm[2]};
        end
        n_tests++;
        if (s0 !== 16'b1111000011110000) begin
            n_fail++; $display("FAIL presc_period8: got %b expected %b", s0, 16'b1111000011110000);
        end
        n_tests++;
        if (s1 !== 16'h0000) begin
            n_fail++; $display("FAIL duty_zero_low: got %b expected %b", s1, 16'h0000);
        end
        n_tests++;
        if (s2 !== 16'hFFFF) begin
            n_fail++; $display("FAIL duty_gt_period_high: got %b expected %b", s2, 16'hFFFF);
        end
        bus_read(32'h8, 4'h4, d, e, v, id);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL presc_wrap: got %h expected 1", d);
        end
    endtask

    task automatic test_double_buffer();
        logic [19:0] seq; logic e;
        do_reset();
        bus_write(32'h4, 32'd9, 4'hF, e);
        bus_write(32'h10, 32'd3, 4'hF, e);
        bus_write(32'h0, 32'h1, 4'hF, e);
        repeat (3) @(negedge clk);
        bus_write(32'h10, 32'd7, 4'hF, e);
        seq = 20'(pwm[0]);
        for (int k = 1; k < 20; k++) begin
            @(negedge clk);
            seq = {seq[18:0], pwm[0]};
        end
        n_tests++;
        if (seq !== 20'b000000_1111111_000_1111) begin
            n_fail++; $display("FAIL dbuf_wave: got %b expected %b", seq, 20'b000000_1111111_000_1111);
        end
    endtask

    task automatic test_interrupt();
        logic [31:0] d; logic e, v; logic [3:0] id;
        do_reset();
        bus_write(32'h4, 32'd9, 4'hF, e);
        bus_write(32'h0, 32'h3, 4'hF, e);
        repeat (9) @(negedge clk);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_before_wrap: got %b expected 0", irq);
        end
        @(negedge clk);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_first_wrap: got %b expected 1", irq);
        end
        repeat (8) @(negedge clk);
        bus_write(32'h8, 32'h1, 4'hF, e);
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL w1c_vs_wrap: got %b expected 1", irq);
        end
        bus_write(32'h8, 32'h1, 4'hF, e);
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL w1c_clear: got %b expected 0", irq);
        end
        bus_read(32'h8, 4'h5, d, e, v, id);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL status_cleared: got %h expected 0", d);
        end
    endtask

    task automatic test_bus_protocol();
        logic [31:0] d; logic e, v; logic [3:0] id;
        do_reset();
        bus_write(32'h4, 32'h1234, 4'hF, e);
        bus_write(32'h0, 32'hFFFF_FFFE, 4'hF, e);
        bus_read(32'h0, 4'h1, d, e, v, id);
        n_tests++;
        if (d !== 32'h0000_FF02) begin
            n_fail++; $display("FAIL ctrl_unused_bits: got %h expected %h", d, 32'h0000_FF02);
        end
        @(negedge clk);
        req = '0; req.req = 1'b1; req.a.addr = 32'h4; req.a.be = 4'hF; req.a.aid = 4'h5;
        #1;
        n_tests++;
        if (rsp.gnt !== 1'b1) begin
            n_fail++; $display("FAIL gnt_comb: got %b expected 1", rsp.gnt);
        end
        @(negedge clk);
        n_tests++;
        if ({rsp.rvalid, rsp.r.rid, rsp.r.rdata} !== {1'b1, 4'h5, 32'h1234}) begin
            n_fail++; $display("FAIL b2b_rd1: got %h expected %h",
                               {rsp.rvalid, rsp.r.rid, rsp.r.rdata}, {1'b1, 4'h5, 32'h1234});
        end
        req.a.we = 1'b1; req.a.wdata = 32'h5678; req.a.aid = 4'h6;
        @(negedge clk);
        n_tests++;
        if ({rsp.rvalid, rsp.r.rid, rsp.r.err} !== {1'b1, 4'h6, 1'b0}) begin
            n_fail++; $display("FAIL b2b_wr: got %h expected %h",
                               {rsp.rvalid, rsp.r.rid, rsp.r.err}, {1'b1, 4'h6, 1'b0});
        end
        req.a.we = 1'b0; req.a.aid = 4'h7;
        @(negedge clk);
        n_tests++;
        if ({rsp.rvalid, rsp.r.rid, rsp.r.rdata} !== {1'b1, 4'h7, 32'h5678}) begin
            n_fail++; $display("FAIL b2b_rd2: got %h expected %h",
                               {rsp.rvalid, rsp.r.rid, rsp.r.rdata}, {1'b1, 4'h7, 32'h5678});
        end
        req = '0;
        @(negedge clk);
        n_tests++;
        if (rsp.rvalid !== 1'b0) begin
            n_fail++; $display("FAIL rvalid_drop: got %b expected 0", rsp.rvalid);
        end
        bus_read(32'h3C, 4'h8, d, e, v, id);
        n_tests++;
        if ({e, d} !== {1'b1, 32'h0}) begin
            n_fail++; $display("FAIL err_3c: got %h expected %h", {e, d}, {1'b1, 32'h0});
        end
        bus_read(32'h20, 4'h9, d, e, v, id);
        n_tests++;
        if (e !== 1'b1) begin
            n_fail++; $display("FAIL err_duty4: got %b expected 1", e);
        end
        bus_write(32'hC, 32'hFFFF, 4'hF, e);
        n_tests++;
        if (e !== 1'b0) begin
            n_fail++; $display("FAIL ro_write_err: got %b expected 0", e);
        end
        bus_write(32'h4, 32'hABCD, 4'b0001, e);
        bus_read(32'h4, 4'hA, d, e, v, id);
        n_tests++;
        if (d !== 32'h56CD) begin
            n_fail++; $display("FAIL be_byte0: got %h expected %h", d, 32'h56CD);
        end
    endtask

    task automatic test_enable_reset();
        logic [31:0] d; logic e, v; logic [3:0] id;
        logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        do_reset();
        bus_write(32'h4, 32'd9, 4'hF, e);
        bus_write(32'h10, 32'd5, 4'hF, e);
        bus_write(32'h0, 32'h1, 4'hF, e);
        repeat (12) @(negedge clk);
        n_tests++;
        if (pwm[0] !== 1'b1) begin
            n_fail++; $display("FAIL en_running_high: got %b expected 1", pwm[0]);
        end
        bus_write(32'h0, 32'h0, 4'hF, e);
        @(negedge clk);
        n_tests++;
        if (pwm !== 4'b0) begin
            n_fail++; $display("FAIL en_clear_pwm: got %b expected 0000", pwm);
        end
        bus_read(32'hC, 4'h1, d, e, v, id);
        n_tests++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL en_clear_count: got %h expected 0", d);
        end
        bus_read(32'h8, 4'h2, d, e, v, id);
        n_tests++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL en_clear_wrap_kept: got %h expected 1", d);
        end

        do_reset();
        bus_write(32'h4, 32'd9, 4'hF, e);
        bus_write(32'h10, 32'd5, 4'hF, e);
        bus_write(32'h0, 32'h3, 4'hF, e);
        repeat (11) @(negedge clk);
        n_tests++;
        if ({pwm[0], irq} !== 2'b11) begin
            n_fail++; $display("FAIL pre_reset_active: got %b expected 11", {pwm[0], irq});
        end
        @(negedge clk);
        req = '0; req.req = 1'b1; req.a.addr = 32'h4; req.a.be = 4'hF; req.a.aid = 4'h3;
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({rsp.rvalid, pwm, irq} !== 6'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b expected 000000", {rsp.rvalid, pwm, irq});
        end
        req = '0;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], 4'h4, d, e, v, id);
            n_tests++;
            if (d !== 32'h0) begin
                n_fail++; $display("FAIL post_reset_reg%0d: got %h expected 0", i, d);
            end
        end
    endtask

    initial begin
        req = '0;
        rst = 1'b1;
        test_reset();
        test_basic_pwm();
        test_presc_extremes();
        test_double_buffer();
        test_interrupt();
        test_bus_protocol();
        test_enable_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/user_pwm.md
# user_pwm

OBI subordinate providing `NumChannels` edge-aligned PWM outputs from one shared prescaled timebase, with double-buffered period/duty registers and a period-wrap interrupt. It is one more port on the user subordinate demux in `user_domain`. Its outputs drive GPIO-mux pads, and its `irq_o` feeds one bit of `interrupts_o`.

## Interface
- `ObiCfg`, `SbrObiCfg`: OBI config of the subordinate port.
- `obi_req_t`, `sbr_obi_req_t`: OBI request struct.
- `obi_rsp_t`, `sbr_obi_rsp_t`: OBI response struct.
- `NumChannels`, 4: PWM channels, 1..8.
- `CntWidth`, 16: width of period, duty and counter, 2..32.
- `clk_i`, in, 1: single clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `obi_req_i`, in, `obi_req_t`: subordinate request.
- `obi_rsp_o`, out, `obi_rsp_t`: subordinate response.
- `pwm_o`, out, `NumChannels`: PWM outputs, registered.
- `irq_o`, out, 1: level interrupt.

## Operation
- Register map. Decode uses `addr[5:2]`; offsets are relative to the block base.
  - 0x00 `CTRL`, RW: `[0]` EN, `[1]` IRQ_EN, `[15:8]` PRESC.
  - 0x04 `PERIOD`, RW: `[CntWidth-1:0]`.
  - 0x08 `STATUS`: `[0]` WRAP, write-1-to-clear.
  - 0x0C `COUNT`, RO: current counter value.
  - 0x10+4·i `DUTY[i]`, RW, for i < NumChannels.
  - Any other offset: `err`=1, rdata 0, write ignored.
  - Unused bits read 0.
- Writes honour `be` per byte. A write to a RO register is ignored with `err`=0.
- Double buffering.
  - Programmed PERIOD/DUTY are copied to active registers at every wrap.
  - While EN=0 they are copied every cycle, so enabling always starts with the programmed values.
- Timebase. Runs only while EN=1.
  - The prescaler counts 0..PRESC; a tick occurs in the cycle where prescaler==PRESC, and the prescaler then returns to 0.
  - PRESC=0 means a tick every cycle.
  - On a tick: if counter==active PERIOD, the counter goes to 0, active registers load, and WRAP sets. Otherwise the counter increments.
  - The period is therefore (PERIOD+1)·(PRESC+1) cycles.
- Output compare: `pwm_o[i]` next = EN && (counter < active DUTY[i]).
  - DUTY=0: output constant low.
  - DUTY>PERIOD: output constant high.
- PERIOD=0: the counter stays at 0 and wraps on every tick.
- EN cleared: prescaler and counter are cleared in the same cycle, `pwm_o` goes low on the next edge, and WRAP is kept.
- Interrupt: `irq_o` = IRQ_EN & WRAP, combinational from registers.
- A hardware WRAP set and a same-cycle W1C: the set wins.

## Timing
- `gnt` = `req` combinationally; the block is never backpressured.
- `rvalid` is asserted exactly one cycle after each `req && gnt`. `rid` = captured `aid`.
- Reads return the register value as of the request edge. A read followed by a write in the next cycle returns the pre-write value.
- A register write takes effect at the request edge. `COUNT` reads reflect the counter at that edge.
- Counter to `pwm_o` latency: 1 cycle, registered.
- Reset values:
  - All registers, prescaler and counter: 0.
  - `pwm_o`: 0; `irq_o`: 0; `rvalid`: 0.
  - Response fields: 0.
- Reset mid-transaction: a pending response is dropped; there is no `rvalid` after reset.

## Structure
- `user_pkg`:
  - add demux index `UserPwm`;
  - set `NumDemuxSbr`/`NumDemuxSbrRules` increments;
  - add the address rule (4 KiB window) in `user_addr_map`.
- `user_pwm_reg_pkg`: register offset localparams and the CTRL bit positions.
- Sub-module `user_pwm_timebase`: owns the prescaler, counter, wrap pulse and active-register load strobe. Its inputs are EN, PRESC and active PERIOD.
- The top level holds the OBI register file and the compare logic.

## Test plan
- **Basic PWM**: PERIOD=9, DUTY[0]=3, PRESC=0, EN=1 → `pwm_o[0]` is high 3 cycles and low 7 cycles, repeating with period 10. WRAP sets every 10 cycles.
- **Prescaler and extremes**: PRESC=1, PERIOD=3, DUTY[1]=0, DUTY[2]=4 → period is 8 cycles; `pwm_o[1]` is constant 0 and `pwm_o[2]` is constant 1.
- **Double buffering**: with PERIOD=9 running, write DUTY[0]=7 mid-period → the old duty is kept until the counter wraps, and the first full period after the wrap shows 7 high cycles.
- **Interrupt**: IRQ_EN=1 → `irq_o` rises at the first wrap. A W1C of STATUS issued in the same cycle as a wrap leaves WRAP=1. A later W1C with no wrap clears `irq_o` in the next cycle.
- **Bus protocol**:
  - back-to-back reads give `rvalid` one cycle after each request, with matching `rid`;
  - an access to offset 0x3C gives `err`=1 and rdata 0;
  - a write with `be`=4'b0001 to PERIOD changes only bits [7:0].
- **Enable/reset**:
  - clearing EN mid-period gives `pwm_o`=0 on the next edge and COUNT=0;
  - asserting `rst_i` mid-period and mid-transaction drops all outputs and `rvalid` to 0, and all registers read 0 afterwards.
